valid_rx_fifo: RTL and testbench

Receive-side buffer for the team's valid-only byte stream, the format produced by the 2-stage `in_valid`/`in_data` pipelines. The valid-only stream has no backpressure, so this block absorbs every beat into a small circular FIFO and re-presents it on a ready/valid interface to a downstream consumer that may stall. Beats that arrive while the FIFO is full and not draining are dropped and latched into a sticky overflow flag.

---
 rtl/valid_stream_pkg.sv | 19 +
 rtl/valid_rx_fifo.sv | 89 ++++++++
 tb/tb_valid_rx_fifo.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/valid_stream_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// valid_stream_pkg : shared constants and pointer helpers for valid-only streams
// Revision: 1.0
// ---------------------------------------------------------------------------
package valid_stream_pkg;

  localparam int STREAM_DATA_W = 8;
  localparam int STREAM_DEPTH  = 4;

  // Pointer width for a power-of-two ring: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [ptr_width(STREAM_DEPTH)-1:0] ptr_t;

endpackage
`default_nettype wire

// File: rtl/valid_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// valid_rx_fifo : absorbs a valid-only byte stream into a FWFT ring buffer
//                 with ready/valid output and a sticky overflow flag
// Revision: 1.0
// ---------------------------------------------------------------------------
module valid_rx_fifo
  import valid_stream_pkg::*;
#(
  parameter int DATA_W = STREAM_DATA_W,
  parameter int DEPTH  = STREAM_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = ptr_width(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic w_empty, w_full, w_pop, w_push, w_drop;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign w_pop   = !w_empty && out_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (w_push) begin
      mem_d[wr_ptr_q[IDX_W-1:0]] = in_data;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (w_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = mem_q[rd_ptr_q[IDX_W-1:0]];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_valid_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_valid_rx_fifo : directed self-checking bench for valid_rx_fifo (DEPTH=4)
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_valid_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       overflow;
  logic       ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  valid_rx_fifo #(.DATA_W(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic v, input logic [7:0] d,
                           input logic [2:0] c, input logic o);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".out_data"},  32'(out_data),  32'(d));
    chk({tag, ".count"},     32'(count),     32'(c));
    chk({tag, ".overflow"},  32'(overflow),  32'(o));
  endtask

  task automatic fill(input logic [7:0] base);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      cycle();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int sent;
    int rcv;
    int cyc;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    #3;
    chk_state("reset", 1'b0, 8'h00, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_state("idle", 1'b0, 8'h00, 3'd0, 1'b0);
    end

    // Three pushes with consumer stalled, then drain in order.
    in_valid = 1'b1; in_data = 8'h11; cycle();
    chk_state("push1", 1'b1, 8'h11, 3'd1, 1'b0);
    in_data = 8'h22; cycle();
    chk_state("push2", 1'b1, 8'h11, 3'd2, 1'b0);
    in_data = 8'h33; cycle();
    chk_state("push3", 1'b1, 8'h11, 3'd3, 1'b0);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk_state("pop1", 1'b1, 8'h22, 3'd2, 1'b0);
    cycle();
    chk_state("pop2", 1'b1, 8'h33, 3'd1, 1'b0);
    cycle();
    chk("pop3.count", 32'(count), 32'd0);
    chk("pop3.out_valid", 32'(out_valid), 32'd0);
    cycle();
    chk("ready_empty.count", 32'(count), 32'd0);

    // Fill, drop a beat, drain only the original four.
    fill(8'hA0);
    chk_state("full_a", 1'b1, 8'hA0, 3'd4, 1'b0);
    in_valid = 1'b1; in_data = 8'hA4; cycle();
    chk_state("drop_a4", 1'b1, 8'hA0, 3'd4, 1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_a.out_data", 32'(out_data), 32'(8'hA0 + 8'(i)));
      cycle();
    end
    chk("drain_a.count", 32'(count), 32'd0);
    chk("drain_a.out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    chk("ovf_clr_alone", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop.
    fill(8'hC0);
    in_valid = 1'b1; in_data = 8'hB0; out_ready = 1'b1; cycle();
    chk_state("full_push_pop", 1'b1, 8'hC1, 3'd4, 1'b0);
    in_valid = 1'b0;
    chk("drain_b.0", 32'(out_data), 32'hC1); cycle();
    chk("drain_b.1", 32'(out_data), 32'hC2); cycle();
    chk("drain_b.2", 32'(out_data), 32'hC3); cycle();
    chk("drain_b.3", 32'(out_data), 32'hB0); cycle();
    chk("drain_b.count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Drop coinciding with clear: set wins.
    fill(8'hD0);
    in_valid = 1'b1; in_data = 8'hD4; ovf_clr = 1'b1; cycle();
    in_valid = 1'b0; ovf_clr = 1'b0;
    chk("set_wins.overflow", 32'(overflow), 32'd1);
    chk("set_wins.count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_d.out_data", 32'(out_data), 32'(8'hD0 + 8'(i)));
      cycle();
    end
    out_ready = 1'b0;
    ovf_clr = 1'b1; cycle(); ovf_clr = 1'b0;
    chk("ovf_clr_again", 32'(overflow), 32'd0);

    // 20-beat stream, out_ready toggling 1,0,1,0; beats every other cycle.
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 20 && cyc < 200) begin
      in_valid  = (sent < 20) && (cyc % 2 == 0);
      in_data   = 8'(sent);
      out_ready = (cyc % 2 == 0);
      if (out_valid && out_ready) begin
        chk("stream.out_data", 32'(out_data), 32'(rcv));
        rcv++;
      end
      if (in_valid) sent++;
      cycle();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stream.received", 32'(rcv), 32'd20);
    chk("stream.overflow", 32'(overflow), 32'd0);
    chk("stream.count", 32'(count), 32'd0);

    // Asynchronous reset mid-cycle while full with overflow set.
    fill(8'hE0);
    in_valid = 1'b1; in_data = 8'hE4; cycle(); in_valid = 1'b0;
    chk_state("pre_rst", 1'b1, 8'hE0, 3'd4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_state("async_rst", 1'b0, 8'h00, 3'd0, 1'b0);
    cycle();
    rst_n = 1'b1;
    cycle();
    chk_state("post_rst", 1'b0, 8'h00, 3'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
